vga_display_engine: RTL

VGA_DISPLAY_ENGINE -- requirements
Module: vga_display_engine

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_gen.sv | 74 +++++++
 rtl/vga_display_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, default-width colour struct and the
// line/frame total helpers used by the VGA display engine.
//   DEF_*        - 640x480@60 style timing defaults
//   CNT_W        - width of the pix_x / pix_y counters
//   rgb_t        - {r,g,b} at the default colour width
//   h_total/v_total - porch/sync/active sums
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 8;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    // Modules with a non-default COLOR_W declare the same layout locally.
    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: scan counters, raw sync/de decode and frame bookkeeping.
//   clk, rst (async, active-low), pix_ce (pixel tick)
//   pix_x, pix_y   - current scan coordinate
//   hs_act, vs_act - sync asserted (polarity applied by the caller)
//   de             - coordinate is visible
//   frame_start    - tick at (0,0); combinational so it lines up with pixel (0,0)
//   frame_cnt      - completed frames, first frame after reset not counted
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             hs_act,
    output logic             vs_act,
    output logic             de,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic seen_first;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (pix_ce) begin
            if (pix_x == H_LAST) begin
                pix_x <= '0;
                pix_y <= (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                pix_x <= pix_x + 1'b1;
            end
        end
    end

    // Gated by rst so nothing pulses while held in reset; (0,0) is only
    // present for one tick, so the pulse is one clk even with pix_ce stuck high.
    assign frame_start = rst && pix_ce && (pix_x == '0) && (pix_y == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_first <= 1'b0;
            frame_cnt  <= '0;
        end else if (frame_start) begin
            seen_first <= 1'b1;
            if (seen_first) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign de     = (int'(pix_x) < H_ACTIVE) && (int'(pix_y) < V_ACTIVE);
    assign hs_act = (int'(pix_x) >= H_ACTIVE + H_FP) && (int'(pix_x) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act = (int'(pix_y) >= V_ACTIVE + V_FP) && (int'(pix_y) < V_ACTIVE + V_FP + V_SYNC);
endmodule

// File: rtl/vga_display_engine.sv
// vga_display_engine: VGA timing plus a frame-latched priority mux over
// NUM_LAYERS colour sources.
//   clk, rst (async, active-low), pix_ce (pixel tick)
//   layer_en   - per-layer request, latched at frame_start
//   layer_rgb  - packed {r,g,b} per layer, layer 0 in the LSBs
//   pix_x/pix_y - scan coordinate sent to the layers
//   hsync/vsync/de/r_red/r_green/r_blue - delayed LAYER_LAT+1 ticks so they
//                line up with the layer colour for the same coordinate
//   frame_start, frame_cnt - frame pulse and completed-frame count
module vga_display_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   NUM_LAYERS = 3,
    parameter int   COLOR_W    = DEF_COLOR_W,
    parameter int   LAYER_LAT  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pix_ce,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
    output logic [CNT_W-1:0]                pix_x,
    output logic [CNT_W-1:0]                pix_y,
    output logic                            hsync,
    output logic                            vsync,
    output logic                            de,
    output logic [COLOR_W-1:0]              r_red,
    output logic [COLOR_W-1:0]              r_green,
    output logic [COLOR_W-1:0]              r_blue,
    output logic                            frame_start,
    output logic [15:0]                     frame_cnt
);
    if (LAYER_LAT < 0 || LAYER_LAT > 3) begin : g_bad_lat
        $error("vga_display_engine: LAYER_LAT must be 0..3");
    end

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } tim_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_rgb_t;

    localparam int             SEL_W    = $clog2(NUM_LAYERS + 1);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(NUM_LAYERS);

    logic hs_now, vs_now, de_now;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .pix_ce     (pix_ce),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hs_act     (hs_now),
        .vs_act     (vs_now),
        .de         (de_now),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    // tap[i] is the timing word for the coordinate presented i ticks ago;
    // vld_pipe[LAYER_LAT] is the registered output stage.
    tim_t vld_pipe [LAYER_LAT:0];
    tim_t tap      [LAYER_LAT:0];

    always_comb begin
        tap[0] = '{hs: hs_now, vs: vs_now, de: de_now};
        for (int i = 1; i <= LAYER_LAT; i++) tap[i] = vld_pipe[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= LAYER_LAT; i++) vld_pipe[i] <= '0;
        end else if (pix_ce) begin
            for (int i = 0; i <= LAYER_LAT; i++) vld_pipe[i] <= tap[i];
        end
    end

    // Priority pick: lowest enabled index wins, SEL_NONE when nothing is on.
    logic [SEL_W-1:0] prio_sel, sel_q, sel_eff;

    always_comb begin
        prio_sel = SEL_NONE;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (layer_en[i]) prio_sel = SEL_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             sel_q <= SEL_NONE;
        else if (frame_start) sel_q <= prio_sel;
    end

    // On the frame_start tick itself use the fresh pick, so with
    // LAYER_LAT=0 pixel (0,0) already belongs to the new frame's layer.
    assign sel_eff = frame_start ? prio_sel : sel_q;

    pix_rgb_t layer_pix, rgb_q;

    always_comb begin
        layer_pix = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (sel_eff == SEL_W'(i)) layer_pix = layer_rgb[i*3*COLOR_W +: 3*COLOR_W];
    end

    // Colour is captured alongside the de entering the output stage, so
    // blanking pixels are zero by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rgb_q <= '0;
        else if (pix_ce) rgb_q <= tap[LAYER_LAT].de ? layer_pix : '0;
    end

    assign de      = vld_pipe[LAYER_LAT].de;
    assign hsync   = vld_pipe[LAYER_LAT].hs ? HSYNC_POL : ~HSYNC_POL;
    assign vsync   = vld_pipe[LAYER_LAT].vs ? VSYNC_POL : ~VSYNC_POL;
    assign r_red   = rgb_q.r;
    assign r_green = rgb_q.g;
    assign r_blue  = rgb_q.b;
endmodule
